// File: rtl/traffic_phase_scheduler.sv
// Four-lane phase scheduler: ALL_RED -> GREEN -> YELLOW per granted lane, with
// density-scaled green length, round-robin fairness and siren pre-emption.
module traffic_phase_scheduler #(
    parameter int unsigned MIN_GREEN    = 8,
    parameter int unsigned EXT_PER_CAR  = 4,
    parameter int unsigned MAX_GREEN    = 20,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned TW           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] IR_sensors,
    input  logic [3:0]  sound_sensors,
    output logic [3:0]  lane_green,
    output logic [3:0]  lane_yellow,
    output logic [3:0]  lane_red,
    output logic [1:0]  active_lane,
    output logic        emergency_active
);

    typedef enum logic [1:0] {
        S_ALL_RED,
        S_GREEN,
        S_YELLOW
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [11:0]     ir_q;
    logic [3:0]      snd_q;
    logic [1:0]      last_q;
    logic [1:0]      active_q;
    logic            emerg_q;
    logic [3:0]      green_q;
    logic [3:0]      yellow_q;

    logic [1:0]      pc [4];
    logic [1:0]      idx;
    logic            found;
    logic [1:0]      grant_lane_d;
    logic            grant_emerg_d;
    logic [TW-1:0]   grant_len_d;
    logic            other_siren;

    function automatic logic [1:0] pop3(input logic [2:0] b);
        return 2'(b[0]) + 2'(b[1]) + 2'(b[2]);
    endfunction

    // Sum is formed at 32 bits so the cap compare never sees a wrapped value.
    function automatic logic [TW-1:0] green_len(input logic [1:0] cnt);
        logic [31:0] full;
        full = MIN_GREEN + EXT_PER_CAR * {30'd0, cnt};
        if (full > MAX_GREEN) begin
            full = MAX_GREEN;
        end
        return full[TW-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pc[k] = pop3(ir_q[3*k +: 3]);
        end
        idx           = '0;
        found         = 1'b0;
        grant_lane_d  = last_q + 2'd1;
        grant_emerg_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = last_q + 2'(k + 1);
            if (!found && pc[idx] != 2'd0) begin
                grant_lane_d = idx;
                found        = 1'b1;
            end
        end
        // Descending scan so the lowest-index siren wins.
        for (int k = 3; k >= 0; k--) begin
            if (snd_q[k]) begin
                grant_lane_d  = 2'(k);
                grant_emerg_d = 1'b1;
            end
        end
        grant_len_d = grant_emerg_d ? TW'(MIN_GREEN) : green_len(pc[grant_lane_d]);
    end

    assign other_siren = |(snd_q & ~(4'(1) << active_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q     <= '0;
            snd_q    <= '0;
            state_q  <= S_ALL_RED;
            timer_q  <= TW'(ALL_RED_TIME);
            last_q   <= 2'd3;
            active_q <= 2'd0;
            emerg_q  <= 1'b0;
            green_q  <= '0;
            yellow_q <= '0;
        end else begin
            ir_q  <= IR_sensors;
            snd_q <= sound_sensors;
            case (state_q)
                S_ALL_RED: begin
                    if (timer_q <= TW'(1)) begin
                        state_q  <= S_GREEN;
                        timer_q  <= grant_len_d;
                        active_q <= grant_lane_d;
                        last_q   <= grant_lane_d;
                        emerg_q  <= grant_emerg_d;
                        green_q  <= 4'(1) << grant_lane_d;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_GREEN: begin
                    // Emergency green parks at 1 until its own siren clears.
                    if ((emerg_q && timer_q <= TW'(1) && !snd_q[active_q]) ||
                        (!emerg_q && (timer_q <= TW'(1) || other_siren))) begin
                        state_q  <= S_YELLOW;
                        timer_q  <= TW'(YELLOW_TIME);
                        emerg_q  <= 1'b0;
                        green_q  <= '0;
                        yellow_q <= green_q;
                    end else if (timer_q > TW'(1)) begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_YELLOW: begin
                    if (timer_q <= TW'(1)) begin
                        state_q  <= S_ALL_RED;
                        timer_q  <= TW'(ALL_RED_TIME);
                        yellow_q <= '0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q  <= S_ALL_RED;
                    timer_q  <= TW'(ALL_RED_TIME);
                    emerg_q  <= 1'b0;
                    green_q  <= '0;
                    yellow_q <= '0;
                end
            endcase
        end
    end

    assign lane_green       = green_q;
    assign lane_yellow      = yellow_q;
    assign lane_red         = ~(green_q | yellow_q);
    assign active_lane      = active_q;
    assign emergency_active = emerg_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase-by-phase lamp timelines
// with hand-computed lengths, plus per-cycle lamp invariants.
module tb_traffic_phase_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ir = '0;
    logic [3:0]  snd = '0;
    logic [3:0]  lane_green, lane_yellow, lane_red;
    logic [1:0]  active_lane;
    logic        emergency_active;

    int n_cmp = 0;
    int n_err = 0;

    traffic_phase_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .IR_sensors       (ir),
        .sound_sensors    (snd),
        .lane_green       (lane_green),
        .lane_yellow      (lane_yellow),
        .lane_red         (lane_red),
        .active_lane      (active_lane),
        .emergency_active (emergency_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_cmp++;
        assert (lane_red === ~(lane_green | lane_yellow) && $countones(~lane_red) <= 1 &&
                !(|lane_green && |lane_yellow))
        else begin
            n_err++;
            $error("FAIL lamp_invariant observed g=%b y=%b r=%b required r=~(g|y) with at most one lane non-red",
                   lane_green, lane_yellow, lane_red);
        end
    end

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed={g,y,r,lane,em}=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expects n consecutive cycles showing the given lamps/lane/emergency flag.
    task automatic phase(input string tag, input logic [3:0] g, input logic [3:0] y,
                         input logic [1:0] al, input logic em, input int n);
        logic [14:0] exp_v;
        exp_v = {g, y, ~(g | y), al, em};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i),
                {lane_green, lane_yellow, lane_red, active_lane, emergency_active}, exp_v);
        end
    endtask

    task automatic do_reset(input logic [11:0] ir_v, input logic [3:0] snd_v);
        reset = 1'b0;
        ir    = ir_v;
        snd   = snd_v;
        #1;
        chk("reset_state", {lane_green, lane_yellow, lane_red, active_lane, emergency_active},
            {4'h0, 4'h0, 4'hF, 2'd0, 1'b0});
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // T1: idle intersection, plain rotation 0,1,2,3,0
        do_reset(12'h000, 4'h0);
        phase("t1_ar0", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t1_g0",  4'h1, 4'h0, 2'd0, 1'b0, 8);
        phase("t1_y0",  4'h0, 4'h1, 2'd0, 1'b0, 3);
        phase("t1_ar1", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t1_g1",  4'h2, 4'h0, 2'd1, 1'b0, 8);
        phase("t1_y1",  4'h0, 4'h2, 2'd1, 1'b0, 3);
        phase("t1_ar2", 4'h0, 4'h0, 2'd1, 1'b0, 2);
        phase("t1_g2",  4'h4, 4'h0, 2'd2, 1'b0, 8);
        phase("t1_y2",  4'h0, 4'h4, 2'd2, 1'b0, 3);
        phase("t1_ar3", 4'h0, 4'h0, 2'd2, 1'b0, 2);
        phase("t1_g3",  4'h8, 4'h0, 2'd3, 1'b0, 8);
        phase("t1_y3",  4'h0, 4'h8, 2'd3, 1'b0, 3);
        phase("t1_ar4", 4'h0, 4'h0, 2'd3, 1'b0, 2);
        phase("t1_g0b", 4'h1, 4'h0, 2'd0, 1'b0, 8);

        // T2: lanes 0..2 one car each, lane 3 empty and skipped
        do_reset(12'b0001_0010_0010, 4'h0);
        phase("t2_ar0", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t2_g0",  4'h1, 4'h0, 2'd0, 1'b0, 12);
        phase("t2_y0",  4'h0, 4'h1, 2'd0, 1'b0, 3);
        phase("t2_ar1", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t2_g1",  4'h2, 4'h0, 2'd1, 1'b0, 12);
        phase("t2_y1",  4'h0, 4'h2, 2'd1, 1'b0, 3);
        phase("t2_ar2", 4'h0, 4'h0, 2'd1, 1'b0, 2);
        phase("t2_g2",  4'h4, 4'h0, 2'd2, 1'b0, 12);
        phase("t2_y2",  4'h0, 4'h4, 2'd2, 1'b0, 3);
        phase("t2_ar3", 4'h0, 4'h0, 2'd2, 1'b0, 2);
        phase("t2_g0b", 4'h1, 4'h0, 2'd0, 1'b0, 12);

        // T3: lane 3 hits the 20-cycle cap, lane 2 gets 12
        do_reset(12'b1111_0000_0000, 4'h0);
        phase("t3_ar0", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t3_g2",  4'h4, 4'h0, 2'd2, 1'b0, 12);
        phase("t3_y2",  4'h0, 4'h4, 2'd2, 1'b0, 3);
        phase("t3_ar1", 4'h0, 4'h0, 2'd2, 1'b0, 2);
        phase("t3_g3",  4'h8, 4'h0, 2'd3, 1'b0, 20);
        phase("t3_y3",  4'h0, 4'h8, 2'd3, 1'b0, 3);
        phase("t3_ar2", 4'h0, 4'h0, 2'd3, 1'b0, 2);
        phase("t4_g2a", 4'h4, 4'h0, 2'd2, 1'b0, 3);

        // T4: siren on lane 0 pre-empts lane 2 well before MIN_GREEN
        snd = 4'b0001;
        phase("t4_g2b", 4'h4, 4'h0, 2'd2, 1'b0, 1);
        phase("t4_y2",  4'h0, 4'h4, 2'd2, 1'b0, 3);
        phase("t4_ar",  4'h0, 4'h0, 2'd2, 1'b0, 2);
        phase("t4_e0",  4'h1, 4'h0, 2'd0, 1'b1, 12);
        snd = 4'b0000;
        phase("t4_e0end", 4'h1, 4'h0, 2'd0, 1'b1, 1);
        phase("t4_y0",  4'h0, 4'h1, 2'd0, 1'b0, 3);
        phase("t4_ar2", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t4_g2c", 4'h4, 4'h0, 2'd2, 1'b0, 4);
        ir = 12'hFFF;
        phase("t4_g2d", 4'h4, 4'h0, 2'd2, 1'b0, 8);
        phase("t4_y2b", 4'h0, 4'h4, 2'd2, 1'b0, 3);

        // T5: lowest siren wins; other siren waits; emergency green kept to MIN_GREEN
        do_reset(12'h000, 4'b0110);
        phase("t5_ar0", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t5_e1a", 4'h2, 4'h0, 2'd1, 1'b1, 2);
        snd = 4'b0100;
        phase("t5_e1b", 4'h2, 4'h0, 2'd1, 1'b1, 6);
        phase("t5_y1",  4'h0, 4'h2, 2'd1, 1'b0, 3);
        phase("t5_ar1", 4'h0, 4'h0, 2'd1, 1'b0, 2);
        phase("t5_e2",  4'h4, 4'h0, 2'd2, 1'b1, 3);

        // T6: asynchronous reset in the middle of an emergency green, then T1 restarts
        do_reset(12'h000, 4'h0);
        phase("t6_ar0", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t6_g0",  4'h1, 4'h0, 2'd0, 1'b0, 8);
        phase("t6_y0",  4'h0, 4'h1, 2'd0, 1'b0, 3);
        phase("t6_ar1", 4'h0, 4'h0, 2'd0, 1'b0, 2);
        phase("t6_g1",  4'h2, 4'h0, 2'd1, 1'b0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
